// File: rtl/bcd_pkg.sv
// Shared types and elaboration helpers for the sequential binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    typedef logic [3:0] bcd_digit_t;

    // 10**n, evaluated at elaboration to size the saturation threshold
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: add 3 to any BCD digit of 5 or more before the shift.
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Serial shift-add-3 binary-to-BCD converter, one input bit per clock, with
// start/busy/done handshake and saturating overflow for 7-segment drivers.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int unsigned SW     = 4 * DIGITS;
    localparam int unsigned CW     = $clog2(WIDTH + 1);
    localparam int unsigned MAXVAL = pow10(DIGITS) - 1;

    bcd_state_t       r_state;
    bcd_state_t       w_next;
    logic [WIDTH-1:0] r_bin;
    logic [SW-1:0]    r_scr;
    logic [CW-1:0]    r_cnt;
    logic             r_ovf_pend;
    logic             r_busy;
    logic             r_done;
    logic [SW-1:0]    r_bcd;
    logic             r_ovf;
    logic [SW-1:0]    w_adj;
    logic             w_accept;
    logic             w_ovf;

    assign w_accept = (r_state == IDLE) && start;
    // 32-bit compare keeps the threshold safe for any WIDTH/DIGITS combination
    assign w_ovf    = 32'(bin) > MAXVAL;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_scr[4*k +: 4]),
            .o_digit (w_adj[4*k +: 4])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_bin      <= '0;
            r_scr      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_bin      <= bin;
                r_scr      <= '0;
                r_cnt      <= CW'(WIDTH);
                r_ovf_pend <= w_ovf;
                r_busy     <= 1'b1;
            end else if (r_state == SHIFT) begin
                r_scr <= {w_adj[SW-2:0], r_bin[WIDTH-1]};
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt - CW'(1);
            end else if (r_state == DONE) begin
                r_bcd  <= r_ovf_pend ? {DIGITS{4'h9}} : r_scr;
                r_ovf  <= r_ovf_pend;
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: default 8-bit/3-digit instance plus a 10-bit instance for saturation.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic        ovf;
        logic [11:0] bcd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
    logic        overflow;

    logic        start2;
    logic [9:0]  bin2;
    logic        busy2;
    logic        done2;
    logic [11:0] bcd2;
    logic        overflow2;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q[$];
    exp_t hold;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    bin_to_bcd_seq #(.WIDTH(10), .DIGITS(3)) dut2 (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start2),
        .bin      (bin2),
        .busy     (busy2),
        .done     (done2),
        .bcd      (bcd2),
        .overflow (overflow2)
    );

    // Reference: decimal digits by division, saturating at 999
    function automatic exp_t model(input int unsigned v);
        exp_t        e;
        int unsigned x;
        e.ovf = (v > 999);
        x     = e.ovf ? 999 : v;
        e.bcd = {4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on each done, otherwise outputs must hold the last result
    always @(negedge clk) begin
        if (mon_en) begin
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    hold = q.pop_front();
                    check("bcd", 32'(bcd), 32'(hold.bcd));
                    check("overflow", 32'(overflow), 32'(hold.ovf));
                end
            end else begin
                check("bcd_hold", 32'(bcd), 32'(hold.bcd));
                check("ovf_hold", 32'(overflow), 32'(hold.ovf));
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic convert(input logic [7:0] v, output int acc);
        int lat;
        wait_idle();
        bin   = v;
        start = 1'b1;
        @(posedge clk);
        acc = cyc;
        q.push_back(model(32'(v)));
        #1 start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", 32'(lat), 32'd9);
    endtask

    task automatic convert2(input logic [9:0] v);
        int   lat;
        exp_t e;
        e = model(32'(v));
        @(negedge clk);
        bin2   = v;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done2) begin
                lat = k;
                break;
            end
        end
        check("w10_latency", 32'(lat), 32'd11);
        check("w10_bcd", 32'(bcd2), 32'(e.bcd));
        check("w10_overflow", 32'(overflow2), 32'(e.ovf));
        @(posedge clk);
        #1 check("w10_done_pulse", 32'(done2), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int acc;
        int prev;
        reset_n = 1'b0;
        start   = 1'b0;
        bin     = '0;
        start2  = 1'b0;
        bin2    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_bcd", 32'(bcd), 32'h000);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        hold   = '0;
        mon_en = 1'b1;

        convert(8'd255, acc);
        repeat (5) @(posedge clk);

        // Back-to-back sweep: restart as soon as busy drops
        prev = -1;
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), acc);
            if (prev >= 0) check("period", 32'(acc - prev), 32'd10);
            prev = acc;
        end

        for (int i = 0; i < 20; i++) begin
            convert(8'($urandom_range(0, 255)), acc);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        // Starts while busy (SHIFT at t+3, DONE at t+9) must be dropped
        wait_idle();
        bin   = 8'd42;
        start = 1'b1;
        @(posedge clk);
        q.push_back(model(42));
        #1 start = 1'b0;
        bin = 8'd200;
        repeat (2) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("ign_done", 32'(done), 32'd1);
        check("ign_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 check("ign_not_queued", 32'(busy), 32'd0);
        convert(8'd200, acc);

        // Reset mid-conversion discards the partial result
        wait_idle();
        bin   = 8'd137;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1;
        hold = '0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_bcd", 32'(bcd), 32'h000);
        check("midrst_overflow", 32'(overflow), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (12) @(posedge clk);
        convert(8'd137, acc);

        // 10-bit instance: saturation boundary
        convert2(10'd1000);
        convert2(10'd999);
        convert2(10'd1023);
        convert2(10'd0);
        for (int i = 0; i < 8; i++) convert2(10'($urandom_range(0, 1023)));

        repeat (15) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock. It sits directly upstream of the 7-segment hex decoders. Each 4-bit BCD digit output drives one decoder's 4-bit count input, so board HEX displays show decimal values 0-9 per digit instead of hex. A start/busy/done handshake lets a controller request a conversion and know when the digits are stable.

Parameters:
WIDTH, 8, bit width of the binary input (1..16).
DIGITS, 3, number of BCD digits produced (1..5).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
start  input  1  conversion request; accepted only when busy=0.
bin  input  WIDTH  unsigned binary value; sampled in the cycle start is accepted.
busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
done  output  1  one-cycle pulse when the bcd output updates.
bcd  output  4*DIGITS  packed BCD; digit k occupies bits [4k+3:4k], digit 0 is the ones digit; held stable between done pulses.
overflow  output  1  high when the last accepted bin exceeded 10^DIGITS-1; held with bcd.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift/count registers cleared. Reset overrides everything, including mid-conversion. A partial result is discarded and never appears on bcd.
- States: IDLE, SHIFT, DONE (enum in package).
- IDLE: busy=0. When start=1 at an edge:
  - latch bin into the binary shift register;
  - clear the BCD scratch register;
  - load bit counter = WIDTH;
  - latch ovf_pending = (bin > 10^DIGITS-1);
  - go to SHIFT.
- SHIFT: busy=1. Each cycle, first apply adjust-add-3 to every scratch digit whose value is >=5. Then shift {scratch, binary} left by one, moving the binary MSB into the scratch LSB. Decrement the counter. After the cycle in which the counter reaches 0 (exactly WIDTH SHIFT cycles), go to DONE.
- DONE: busy=1, done=1 for exactly this cycle.
  - bcd <= scratch, or all digits = 9 if ovf_pending (saturate).
  - overflow <= ovf_pending.
  - Next state is IDLE unconditionally.
- Latency: start accepted at edge t. SHIFT occupies edges t+1..t+WIDTH. done and the new bcd/overflow are visible after edge t+WIDTH+1. Default parameters: 9 cycles from start to done.
- start while busy=1 (SHIFT or DONE) is ignored and not queued. The earliest accepted restart is the first IDLE cycle after DONE, giving a minimum period of WIDTH+2 cycles.
- bin changes after acceptance have no effect on the running conversion.
- bcd/overflow change only in DONE or on reset, never mid-conversion. This prevents decoder flicker.
- Scratch register width is 4*DIGITS. Bits shifted out of the top are dropped; overflow saturation covers that case.
- The adjust step is purely combinational per digit: out = (in >= 5) ? in + 3 : in, 4-bit result. Input values 10-15 cannot occur in valid operation.
- Elaboration-time constant MAXVAL = 10^DIGITS-1, computed with WIDTH+1-bit-safe comparison.

Decomposition:
- Package bcd_pkg holds:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  - typedef logic [3:0] bcd_digit_t;
  - a constant function pow10(n) used for MAXVAL.
- One sub-module, bcd_digit_adj (4-bit in, 4-bit out, combinational add-3), instantiated DIGITS times via generate.
- Top level: bin_to_bcd_seq holds the FSM, counter and registers.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, release -> bcd=12'h000, busy=0, done=0, overflow=0.
- bin=8'd255, start pulse at edge t -> busy high from t+1, done=1 exactly at t+9, bcd=12'h255, overflow=0; bcd unchanged afterward.
- Sweep bin=0..255 back-to-back (start as soon as busy=0) -> each done gives the correct BCD, e.g. 0->12'h000, 9->12'h009, 10->12'h010, 99->12'h099, 100->12'h100, 199->12'h199. Period is exactly 10 cycles.
- bin=8'd42 start, then bin=8'd200 with start=1 at t+3 and t+9 -> both extra starts ignored, one done, bcd=12'h042; next idle start converts 200 -> 12'h200.
- Reset mid-conversion: start 8'd137, reset_n=0 at t+4 -> bcd=000, busy=0, no done pulse. A later start converts 137 -> 12'h137.
- WIDTH=10, DIGITS=3: bin=10'd1000 -> bcd=12'h999, overflow=1. Then bin=10'd999 -> bcd=12'h999, overflow=0.
